// File: rtl/rff_bank_arb.sv
// Shared register bank written by NREQ requesters through a round-robin arbiter,
// with a sequencer that zeroes the bank one entry per cycle on request.
module rff_bank_arb #(
  parameter  int NREQ  = 4,
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   wr_addr,
  input  logic [NREQ*DW-1:0]   wr_data,
  output logic [NREQ-1:0]      gnt,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic [1:0]           dbg_state
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]   bank_q [DEPTH];
  logic [DW-1:0]   bank_d [DEPTH];
  logic            clr_busy_q, clr_busy_d;
  logic            clr_done_q, clr_done_d;

  logic            arb_en;
  logic            found;
  logic [PW-1:0]   winner;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // Handshake: gnt[i] is combinational from req and rr_ptr; the write of
  // requester i happens at the rising edge where gnt[i]=1. A requester keeps
  // its wr_addr/wr_data stable while req[i]=1 until that edge, and may drop
  // req[i] at any time without penalty.
  always_comb begin
    int idx;
    found = 1'b0;
    winner = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign win_addr = wr_addr[int'(winner)*AW +: AW];
  assign win_data = wr_data[int'(winner)*DW +: DW];

  // Grants are held off while in reset so no requester sees a phantom grant.
  assign arb_en = (state_q == ST_IDLE) && !clr_req && !reset;

  always_comb begin
    gnt = '0;
    if (arb_en && found) gnt[winner] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    bank_d   = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (found) begin
          rr_ptr_d = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
          // Out-of-range addresses match no entry, so the write is dropped.
          for (int e = 0; e < DEPTH; e++) begin
            if (int'(win_addr) == e) bank_d[e] = win_data;
          end
        end
      end
      ST_CLEAR: begin
        for (int e = 0; e < DEPTH; e++) begin
          if (int'(cnt_q) == e) bank_d[e] = '0;
        end
        if (int'(cnt_q) == DEPTH - 1) state_d = ST_DONE;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    clr_busy_d = (state_d == ST_CLEAR);
    clr_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      bank_q     <= '{default: '0};
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      bank_q     <= bank_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (int'(rd_addr) == e) rd_data = bank_q[e];
    end
  end

  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;
  assign dbg_state = state_q;

endmodule
